// File: rtl/toggle_period_meter_pkg.sv
// Shared definitions for the toggle period meter.
//   - meter_state_e : measurement FSM states
//   - *Default      : default widths and synchroniser depth
//   - CntSatDefault : saturation value of the default-width period counter
package toggle_period_meter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StArmed
  } meter_state_e;

  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned EdgeWDefault      = 8;
  localparam int unsigned SyncStagesDefault = 2;

  localparam logic [CntWDefault-1:0] CntSatDefault = {CntWDefault{1'b1}};

endpackage

// File: rtl/toggle_period_meter_sync_edge_detect.sv
// Synchroniser chain plus rising-edge pulse for an asynchronous level input.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (chain cleared to 0)
//   d_i    : asynchronous level input
//   rise_o : one-cycle pulse when the synchronised level goes 0 -> 1
// A rise on d_i sampled at edge n is flagged during the cycle after edge n+SyncStages-1,
// so the consumer acts on it at edge n+SyncStages.
module toggle_period_meter_sync_edge_detect
  import toggle_period_meter_pkg::*;
#(
  parameter int unsigned SyncStages = SyncStagesDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign rise_o = sync_q[SyncStages-1] & ~prev_q;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the clk-cycle spacing between rising edges of an asynchronous toggle output.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   q_in               : toggle flip-flop output (asynchronous)
//   en                 : measurement enable; low forces IDLE and discards the running count
//   clear              : synchronous clear of overflow, missed, edge_count
//   period_o           : last accepted period, in clk cycles (saturating)
//   period_valid/ready : result handshake
//   edge_count         : wrapping count of rising edges seen while en=1
//   overflow, missed   : sticky flags (saturated period / result dropped under backpressure)
module toggle_period_meter
  import toggle_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned EDGE_W      = EdgeWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              q_in,
  input  logic              en,
  input  logic              clear,
  output logic [CNT_W-1:0]  period_o,
  output logic              period_valid,
  input  logic              period_ready,
  output logic [EDGE_W-1:0] edge_count,
  output logic              overflow,
  output logic              missed
);

  localparam logic [CNT_W-1:0] CntSat = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  meter_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise;
  logic             load_ok;

  toggle_period_meter_sync_edge_detect #(
    .SyncStages(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rstn),
    .d_i   (q_in),
    .rise_o(rise)
  );

  // A result may load if the slot is empty or is being consumed this very cycle.
  always_comb begin
    load_ok = !period_valid || period_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      period_o     <= '0;
      period_valid <= 1'b0;
      edge_count   <= '0;
      overflow     <= 1'b0;
      missed       <= 1'b0;
    end else begin
      // Consumption first; a same-cycle load below overrides it.
      if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end

      if (!en) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              state_q <= StArmed;
              cnt_q   <= CntOne;
            end
          end
          StArmed: begin
            if (rise) begin
              cnt_q <= CntOne;
              if (cnt_q == CntSat) begin
                overflow <= 1'b1;
              end
              if (load_ok) begin
                period_o     <= cnt_q;
                period_valid <= 1'b1;
              end else begin
                missed <= 1'b1;
              end
            end else if (cnt_q != CntSat) begin
              cnt_q <= cnt_q + CntOne;
            end
          end
        endcase

        if (rise) begin
          edge_count <= edge_count + 1'b1;
        end
      end

      // Clear wins over any flag set or edge increment in the same cycle.
      if (clear) begin
        overflow   <= 1'b0;
        missed     <= 1'b0;
        edge_count <= '0;
      end
    end
  end

endmodule
